// File: rtl/program_sequencer.sv
// Program counter with jump, call/return stack, halt/resume and a configurable end-of-memory policy.
// Address updates one cycle after next is sampled high. There is no backpressure: the sequencer steps only on next.
module program_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    parameter int WRAP_EN     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              next,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] address,
    output logic              halted,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt, addr_inc, ret_addr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic              push, ovf_set, unf_set, inc_req, at_max;

    // Return address is always taken modulo 2^ADDR_W, independent of WRAP_EN.
    assign addr_inc    = address + ADDR_W'(1);
    assign at_max      = &address;
    assign push_idx    = IDX_W'(count);
    assign pop_idx     = IDX_W'(count - CNT_W'(1));
    assign ret_addr    = stack[pop_idx];
    assign stack_empty = (count == '0);
    assign stack_full  = (count == CNT_W'(STACK_DEPTH));
    assign halted      = (state == HALTED);

    always_comb begin
        state_nxt = state;
        addr_nxt  = address;
        count_nxt = count;
        push      = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        inc_req   = 1'b0;
        case (state)
            RUN: begin
                if (next) begin
                    if (halt_req) begin
                        state_nxt = HALTED;
                    end else if (call_en) begin
                        if (!stack_full) begin
                            push      = 1'b1;
                            addr_nxt  = jump_addr;
                            count_nxt = count + CNT_W'(1);
                        end else begin
                            ovf_set = 1'b1;
                            inc_req = 1'b1;
                        end
                    end else if (ret_en) begin
                        if (!stack_empty) begin
                            addr_nxt  = ret_addr;
                            count_nxt = count - CNT_W'(1);
                        end else begin
                            unf_set = 1'b1;
                            inc_req = 1'b1;
                        end
                    end else if (jump_en) begin
                        addr_nxt = jump_addr;
                    end else begin
                        inc_req = 1'b1;
                    end
                    // Without wrapping, running off the end parks the sequencer.
                    if (inc_req) begin
                        if (at_max && (WRAP_EN == 0)) begin
                            state_nxt = HALTED;
                        end else begin
                            addr_nxt = addr_inc;
                        end
                    end
                end
            end
            HALTED: begin
                if (resume) begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            address       <= ADDR_W'(RESET_ADDR);
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            address       <= addr_nxt;
            count         <= count_nxt;
            overflow_err  <= overflow_err | ovf_set;
            underflow_err <= underflow_err | unf_set;
        end
    end

    // Entries above the count are dead, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= addr_inc;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: two sequencers (wrapping and halting at end of memory) share stimulus
// and are compared against a queue-based reference model of the sequencing rules.
module tb_program_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          halted;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          next, jump_en, call_en, ret_en, halt_req, resume;
    logic [AW-1:0] jump_addr;

    logic [AW-1:0] addr0, addr1;
    logic          halted0, empty0, full0, ovf0, unf0;
    logic          halted1, empty1, full1, ovf1, unf1;
    obs_t          act0, act1;

    int checks   = 0;
    int failures = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t e0, e1;

    // Reference model state: index 0 = wrapping DUT, 1 = halting DUT.
    int m_addr [2];
    bit m_halt [2];
    bit m_ovf  [2];
    bit m_unf  [2];
    int m_stk0[$];
    int m_stk1[$];

    always #5 clk = ~clk;

    program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0), .WRAP_EN(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .next(next), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume),
        .address(addr0), .halted(halted0), .stack_empty(empty0), .stack_full(full0),
        .overflow_err(ovf0), .underflow_err(unf0)
    );

    program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0), .WRAP_EN(0)) u_hold (
        .clk(clk), .reset_n(reset_n), .next(next), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .jump_addr(jump_addr), .halt_req(halt_req), .resume(resume),
        .address(addr1), .halted(halted1), .stack_empty(empty1), .stack_full(full1),
        .overflow_err(ovf1), .underflow_err(unf1)
    );

    assign act0 = {addr0, halted0, empty0, full0, ovf0, unf0};
    assign act1 = {addr1, halted1, empty1, full1, ovf1, unf1};

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got addr=%02h halted=%0b empty=%0b full=%0b ovf=%0b unf=%0b, expected addr=%02h halted=%0b empty=%0b full=%0b ovf=%0b unf=%0b",
                     nm, $time, act.addr, act.halted, act.empty, act.full, act.ovf, act.unf,
                     exp.addr, exp.halted, exp.empty, exp.full, exp.ovf, exp.unf);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = 0;
            m_halt[d] = 1'b0;
            m_ovf[d]  = 1'b0;
            m_unf[d]  = 1'b0;
        end
        m_stk0.delete();
        m_stk1.delete();
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? m_stk0.size() : m_stk1.size();
    endfunction

    function automatic obs_t expect_of(input int d);
        obs_t o;
        o.addr   = AW'(m_addr[d]);
        o.halted = m_halt[d];
        o.empty  = (depth_of(d) == 0);
        o.full   = (depth_of(d) == DEPTH);
        o.ovf    = m_ovf[d];
        o.unf    = m_unf[d];
        return o;
    endfunction

    // Plain-arithmetic rendering of one cycle: halt > call > ret > jump > increment.
    task automatic model_step(input int d, input bit nx, input bit jp, input bit cl, input bit rt,
                              input int ja, input bit hr, input bit rs);
        bit bump;
        int top;
        bump = 1'b0;
        if (m_halt[d]) begin
            if (rs) m_halt[d] = 1'b0;
            return;
        end
        if (!nx) return;
        if (hr) begin
            m_halt[d] = 1'b1;
        end else if (cl) begin
            if (depth_of(d) < DEPTH) begin
                if (d == 0) m_stk0.push_back((m_addr[d] + 1) % 256);
                else        m_stk1.push_back((m_addr[d] + 1) % 256);
                m_addr[d] = ja;
            end else begin
                m_ovf[d] = 1'b1;
                bump = 1'b1;
            end
        end else if (rt) begin
            if (depth_of(d) > 0) begin
                top = (d == 0) ? m_stk0.pop_back() : m_stk1.pop_back();
                m_addr[d] = top;
            end else begin
                m_unf[d] = 1'b1;
                bump = 1'b1;
            end
        end else if (jp) begin
            m_addr[d] = ja;
        end else begin
            bump = 1'b1;
        end
        if (bump) begin
            if (m_addr[d] == 255) begin
                if (d == 0) m_addr[d] = 0;
                else        m_halt[d] = 1'b1;
            end else begin
                m_addr[d] = m_addr[d] + 1;
            end
        end
    endtask

    task automatic cyc(input bit nx, input bit jp, input bit cl, input bit rt,
                       input int ja, input bit hr, input bit rs);
        @(negedge clk);
        next      = nx;
        jump_en   = jp;
        call_en   = cl;
        ret_en    = rt;
        jump_addr = AW'(ja);
        halt_req  = hr;
        resume    = rs;
        model_step(0, nx, jp, cl, rt, ja, hr, rs);
        model_step(1, nx, jp, cl, rt, ja, hr, rs);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    // Monitor: each expectation is due right after the edge that follows its stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("wrap_dut", act0, e0);
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("hold_dut", act1, e1);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        next      = 1'b0;
        jump_en   = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        jump_addr = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_wrap", act0, expect_of(0));
        chk("reset_hold", act1, expect_of(1));
        @(negedge clk);
        reset_n = 1'b1;

        repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 8'h22, 1, 0);
        cyc(1, 1, 0, 0, 3, 0, 0);
        cyc(1, 0, 1, 0, 8'h40, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);

        cyc(1, 1, 0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 1, 0, 8'h10, 0, 0);
        repeat (5) cyc(1, 0, 0, 1, 0, 0, 0);

        cyc(1, 1, 0, 0, 7, 0, 0);
        cyc(1, 0, 1, 0, 8'h30, 1, 0);
        cyc(1, 1, 0, 0, 8'h55, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        cyc(1, 1, 0, 0, 8'hFF, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 8'h20, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0,
                ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
        end

        cyc(1, 1, 0, 0, 8'h05, 0, 0);
        cyc(1, 0, 1, 0, 8'h60, 0, 0);
        @(negedge clk);
        next      = 1'b1;
        call_en   = 1'b1;
        jump_en   = 1'b0;
        ret_en    = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        jump_addr = 8'h77;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_wrap", act0, expect_of(0));
        chk("async_reset_hold", act1, expect_of(1));
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        @(negedge clk);
        reset_n = 1'b1;
        next    = 1'b0;
        call_en = 1'b0;
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Next-generation program counter.
- Drives the instruction-memory address and advances one step each time the processor asserts its instruction-complete strobe.
- Adds over the plain counter: parametrised address width and reset vector, absolute jump, call/return with a hardware return stack of configurable depth, halt/resume, and a selectable end-of-memory policy.
- Sits between the processor's control circuit (done / branch requests) and the instruction memory.

Parameters:
- ADDR_W, 8, width of program address and stack entries.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, address loaded on reset.
- WRAP_EN, 1, 1 = increment past max address wraps to 0; 0 = increment at max address halts instead.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- next  in  1  instruction complete; enables one sequencer step this cycle.
- jump_en  in  1  load jump_addr on step.
- call_en  in  1  push return address, load jump_addr on step.
- ret_en  in  1  pop stack into address on step.
- jump_addr  in  ADDR_W  target for jump/call.
- halt_req  in  1  enter HALTED on step.
- resume  in  1  leave HALTED.
- address  out  ADDR_W  current program address (registered).
- halted  out  1  high in HALTED state.
- stack_empty  out  1  stack count == 0.
- stack_full  out  1  stack count == STACK_DEPTH.
- overflow_err  out  1  sticky: call attempted while full.
- underflow_err  out  1  sticky: return attempted while empty.

Behaviour:
- Reset (async, reset_n=0) sets:
  - address = RESET_ADDR;
  - state = RUN, halted = 0;
  - stack count = 0, stack_empty = 1, stack_full = 0;
  - overflow_err = underflow_err = 0.
- Stack contents are don't-care after reset.
- Reset asserted mid-operation aborts any step immediately; no partial push or pop survives.
- All state is registered. address changes on the clk edge where next=1 is sampled, so the new address is visible the cycle after next (latency 1).
- States:
  - RUN: steps on next=1.
  - HALTED: next, jump_en, call_en, ret_en and halt_req are ignored; address is frozen.
  - HALTED -> RUN on resume=1. Address is unchanged; the first step after resume uses that address as-is.
  - resume while in RUN: no effect.
- Step in RUN (next=1). Exactly one action, chosen by priority halt_req > call_en > ret_en > jump_en > increment:
  - halt_req: state -> HALTED, address unchanged, stack unchanged.
  - call_en, not full: push address+1 (mod 2^ADDR_W), address = jump_addr, count+1.
  - call_en, full: no push; address = address+1 under the normal increment rule; overflow_err set.
  - ret_en, not empty: address = top entry, count-1.
  - ret_en, empty: address = address+1 under the normal increment rule; underflow_err set.
  - jump_en: address = jump_addr.
  - increment: address = address+1.
- Increment at address = 2^ADDR_W-1:
  - WRAP_EN=1: address = 0.
  - WRAP_EN=0: address holds and state -> HALTED.
- The pushed return address on a call at max address is always computed mod 2^ADDR_W, regardless of WRAP_EN.
- next=0: nothing changes. Control inputs without next are ignored.
- overflow_err and underflow_err clear only on reset.
- stack_full and stack_empty are decoded combinationally from the registered count.

Test Plan:
- Reset then 5 pulses of next, ADDR_W=8 -> address 0,1,2,3,4,5; each change one cycle after its next; stack_empty=1.
- At address 3, call_en with jump_addr=0x40 -> address 0x40, stack_empty=0. Two increments, then ret_en -> address 0x04, stack_empty=1.
- STACK_DEPTH=4: five nested calls to 0x10 starting from address 0 -> fourth call sets stack_full=1. Fifth call yields address+1 and overflow_err=1. Four returns unwind correctly, then a fifth return sets underflow_err=1.
- halt_req with call_en together on a step at address 7 -> halted=1, address stays 7, stack unchanged. next and jump_en ignored while halted. resume -> halted=0; next step gives address 8.
- Increment at 0xFF: WRAP_EN=1 -> address 0x00. WRAP_EN=0 -> address stays 0xFF and halted=1.
- reset_n pulled low asynchronously mid-cycle during a call -> address = RESET_ADDR immediately, stack_empty=1, both error flags 0.
